// File: rtl/i2s_tx_serializer.sv
// Philips-I2S transmit back end: holds one AXI-Stream sample per channel and
// serialises it as SCLK/LRCLK/SDATA derived from the audio master clock.
module i2s_tx_serializer #(
  parameter int unsigned AUD_WIDTH             = 24,
  parameter int unsigned AXI_STREAM_DATA_WIDTH = 32,
  parameter int unsigned AXI_STREAM_TID_WIDTH  = 3,
  parameter int unsigned SCLK_DIV_WIDTH        = 8
) (
  input  logic                             aud_mclk,
  input  logic                             aud_mrst,
  input  logic                             ctrl_en,
  input  logic [SCLK_DIV_WIDTH-1:0]        sclk_div,
  input  logic [AXI_STREAM_DATA_WIDTH-1:0] s_axis_aud_tdata,
  input  logic [AXI_STREAM_TID_WIDTH-1:0]  s_axis_aud_tid,
  input  logic                             s_axis_aud_tvalid,
  output logic                             s_axis_aud_tready,
  output logic                             sclk_out,
  output logic                             lrclk_out,
  output logic                             sdata_out,
  output logic                             underflow,
  output logic                             chan_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [SCLK_DIV_WIDTH-1:0] DivOne = SCLK_DIV_WIDTH'(1);

  state_e                        state_q, state_d;
  logic [SCLK_DIV_WIDTH-1:0]     div_q, div_d;
  logic [SCLK_DIV_WIDTH-1:0]     div_cnt_q, div_cnt_d;
  logic                          sclk_q, sclk_d;
  logic [5:0]                    bit_cnt_q, bit_cnt_d;
  logic                          lrclk_q, lrclk_d;
  logic                          sdata_q, sdata_d;
  logic [AUD_WIDTH-1:0]          shift_q, shift_d;
  logic [1:0][AUD_WIDTH-1:0]     hold_q, hold_d;
  logic [1:0]                    hold_valid_q, hold_valid_d;
  logic                          exp_ch_q, exp_ch_d;
  logic                          underflow_q, underflow_d;
  logic                          chan_err_q, chan_err_d;

  logic                          load;
  logic                          load_ch;
  logic [5:0]                    nxt_cnt;
  logic                          accept;
  logic [AUD_WIDTH-1:0]          beat_sample;

  logic unused_stream_bits;
  assign unused_stream_bits = ^{s_axis_aud_tdata[AXI_STREAM_DATA_WIDTH-1:AUD_WIDTH+4],
                                s_axis_aud_tdata[3:0],
                                s_axis_aud_tid[AXI_STREAM_TID_WIDTH-1:1]};

  assign beat_sample       = s_axis_aud_tdata[AUD_WIDTH+3:4];
  assign s_axis_aud_tready = (state_q == StRun) && ctrl_en && !hold_valid_q[exp_ch_q];
  assign accept            = s_axis_aud_tready && s_axis_aud_tvalid;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    div_cnt_d    = div_cnt_q;
    sclk_d       = sclk_q;
    bit_cnt_d    = bit_cnt_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    exp_ch_d     = exp_ch_q;
    underflow_d  = 1'b0;
    chan_err_d   = 1'b0;
    load         = 1'b0;
    load_ch      = 1'b0;
    nxt_cnt      = bit_cnt_q + 6'd1;

    unique case (state_q)
      StIdle: begin
        div_d        = (sclk_div == '0) ? DivOne : sclk_div;
        div_cnt_d    = '0;
        sclk_d       = 1'b0;
        bit_cnt_d    = '0;
        lrclk_d      = 1'b0;
        sdata_d      = 1'b0;
        shift_d      = '0;
        hold_valid_d = '0;
        exp_ch_d     = 1'b0;
        if (ctrl_en) begin
          state_d = StRun;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (div_cnt_q == div_q - DivOne) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          // Falling SCLK edge advances the slot; a disable only takes effect at frame end.
          if (sclk_q) begin
            if (bit_cnt_q == 6'd63 && !ctrl_en) begin
              state_d      = StIdle;
              sclk_d       = 1'b0;
              bit_cnt_d    = '0;
              lrclk_d      = 1'b0;
              sdata_d      = 1'b0;
              hold_valid_d = '0;
              exp_ch_d     = 1'b0;
            end else begin
              bit_cnt_d = nxt_cnt;
              lrclk_d   = nxt_cnt[5];
              sdata_d   = 1'b0;
              if (nxt_cnt[4:0] == 5'd0) begin
                load    = 1'b1;
                load_ch = nxt_cnt[5];
              end else if (nxt_cnt[4:0] <= 5'(AUD_WIDTH)) begin
                sdata_d = shift_q[AUD_WIDTH-1];
                shift_d = {shift_q[AUD_WIDTH-2:0], 1'b0};
              end
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DivOne;
        end
      end
      default: state_d = StIdle;
    endcase

    // Load sees the pre-edge valid flag, so a beat accepted now waits a frame.
    if (load) begin
      shift_d               = hold_valid_q[load_ch] ? hold_q[load_ch] : '0;
      underflow_d           = !hold_valid_q[load_ch];
      hold_valid_d[load_ch] = 1'b0;
    end

    if (accept) begin
      if (s_axis_aud_tid[0] == exp_ch_q) begin
        hold_d[exp_ch_q]       = beat_sample;
        hold_valid_d[exp_ch_q] = 1'b1;
        exp_ch_d               = ~exp_ch_q;
      end else begin
        chan_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      state_q      <= StIdle;
      div_q        <= DivOne;
      div_cnt_q    <= '0;
      sclk_q       <= 1'b0;
      bit_cnt_q    <= '0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= '0;
      exp_ch_q     <= 1'b0;
      underflow_q  <= 1'b0;
      chan_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      div_cnt_q    <= div_cnt_d;
      sclk_q       <= sclk_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      exp_ch_q     <= exp_ch_d;
      underflow_q  <= underflow_d;
      chan_err_q   <= chan_err_d;
    end
  end

  assign sclk_out  = sclk_q;
  assign lrclk_out = lrclk_q;
  assign sdata_out = sdata_q;
  assign underflow = underflow_q;
  assign chan_err  = chan_err_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: a slot/frame-arithmetic reference model predicts
// every output each MCLK cycle; directed scenarios add absolute bit-pattern checks.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  div;
  logic [31:0] tdata;
  logic [2:0]  tid;
  logic        tvalid;
  logic        tready, sclk, lrclk, sdata, uf, ce;

  always #5 clk = ~clk;

  i2s_tx_serializer u_dut (
    .aud_mclk         (clk),
    .aud_mrst         (rst),
    .ctrl_en          (en),
    .sclk_div         (div),
    .s_axis_aud_tdata (tdata),
    .s_axis_aud_tid   (tid),
    .s_axis_aud_tvalid(tvalid),
    .s_axis_aud_tready(tready),
    .sclk_out         (sclk),
    .lrclk_out        (lrclk),
    .sdata_out        (sdata),
    .underflow        (uf),
    .chan_err         (ce)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  tid;
    logic [31:0] data;
  } beat_t;
  beat_t q[$];

  // Reference model: time since RUN entry (m_k) fixes every waveform position.
  bit        m_run = 0;
  int        m_k   = 0;
  int        m_d   = 1;
  bit [1:0]  m_hv  = '0;
  bit [23:0] m_hold[2];
  bit [23:0] m_cur[2];
  bit        m_exp = 0;
  bit        m_uf  = 0;
  bit        m_ce  = 0;
  bit        m_acc = 0;

  logic cap[128];
  bit   cap_on = 0;
  int   uf_cnt = 0;
  int   ce_cnt = 0;
  int   sd_ones = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_slot();
    return (m_k / (2 * m_d)) % 64;
  endfunction

  function automatic logic [5:0] model_out();
    int   slot, pos;
    logic sc, lr, sd;
    if (!m_run) return {3'b000, m_uf, m_ce, 1'b0};
    slot = m_slot();
    pos  = slot % 32;
    sc   = ((m_k / m_d) % 2) == 1;
    lr   = slot >= 32;
    sd   = (pos >= 1 && pos <= 24) ? m_cur[slot / 32][24 - pos] : 1'b0;
    return {sc, lr, sd, m_uf, m_ce, en && !m_hv[m_exp]};
  endfunction

  task automatic model_load(input int ch);
    m_cur[ch] = m_hv[ch] ? m_hold[ch] : 24'h0;
    m_uf      = !m_hv[ch];
    m_hv[ch]  = 1'b0;
  endtask

  task automatic model_edge();
    bit acc, fall;
    int ns;
    m_uf  = 0;
    m_ce  = 0;
    m_acc = 0;
    if (rst) begin
      m_run = 0; m_hv = '0; m_exp = 0; m_k = 0;
      return;
    end
    if (!m_run) begin
      m_d   = (div == 8'd0) ? 1 : int'(div);
      m_hv  = '0;
      m_exp = 0;
      if (en) begin
        m_run = 1;
        m_k   = 0;
        model_load(0);
      end
      return;
    end
    acc  = en && !m_hv[m_exp] && tvalid;
    fall = ((m_k + 1) % (2 * m_d)) == 0;
    if (fall && m_slot() == 63 && !en) begin
      m_run = 0; m_hv = '0; m_exp = 0; m_k = 0;
      return;
    end
    m_k++;
    ns = m_slot();
    if (fall && (ns == 0 || ns == 32)) model_load(ns / 32);
    if (acc) begin
      m_acc = 1;
      if (tid[0] == m_exp) begin
        m_hold[m_exp] = tdata[27:4];
        m_hv[m_exp]   = 1'b1;
        m_exp         = ~m_exp;
      end else begin
        m_ce = 1;
      end
    end
  endtask

  task automatic tick(input string tag);
    tvalid = (q.size() > 0);
    if (tvalid) begin
      tid   = q[0].tid;
      tdata = q[0].data;
    end
    model_edge();
    @(posedge clk);
    #1;
    if (m_acc) void'(q.pop_front());
    if (cap_on && m_run && m_k < 256 * m_d) cap[m_k / (2 * m_d)] = sdata;
    uf_cnt  += int'(uf);
    ce_cnt  += int'(ce);
    sd_ones += int'(sdata);
    check(tag, 32'({sclk, lrclk, sdata, uf, ce, tready}), 32'(model_out()));
  endtask

  task automatic push(input logic [2:0] t, input logic [31:0] d);
    beat_t b;
    b.tid  = t;
    b.data = d;
    q.push_back(b);
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
    push({2'($urandom), 1'b0}, l);
    push({2'($urandom), 1'b1}, r);
  endtask

  function automatic logic [23:0] cap_word(input int start);
    logic [23:0] w = '0;
    for (int i = 0; i < 24; i++) w = {w[22:0], cap[start + i]};
    return w;
  endfunction

  function automatic logic cap_or(input int a, input int b);
    logic r = 1'b0;
    for (int i = a; i <= b; i++) r = r | cap[i];
    return r;
  endfunction

  task automatic clear_cap();
    for (int i = 0; i < 128; i++) cap[i] = 1'bx;
  endtask

  task automatic go_idle(input string tag);
    en = 0;
    for (int i = 0; i < 200 * m_d && m_run; i++) tick(tag);
    check({tag, "_bound"}, 32'(m_run), 32'd0);
    repeat (2) tick(tag);
  endtask

  task automatic run_to_slot(input string tag, input int slot, input int min_frame);
    for (int i = 0; i < 1000 * m_d; i++) begin
      if (m_run && m_k >= min_frame * 128 * m_d && m_slot() == slot) break;
      tick(tag);
    end
    check({tag, "_bound"}, 32'(m_run && m_slot() == slot), 32'd1);
  endtask

  task automatic check_directed(input string tag, input logic [23:0] l1, input logic [23:0] r0);
    check({tag, "_left"}, 32'(cap_word(65)), 32'(l1));
    check({tag, "_right"}, 32'(cap_word(33)), 32'(r0));
    check({tag, "_pad"},
          32'(cap_or(32, 32) | cap_or(57, 63) | cap_or(64, 64) | cap_or(89, 95)), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1; en = 0; div = 8'd1; tvalid = 0; tid = '0; tdata = '0;
    repeat (3) tick("reset");
    check("reset_outputs", 32'({sclk, lrclk, sdata, uf, ce, tready}), 32'd0);
    rst = 0;
    repeat (2) tick("idle");

    // D = 1 directed pair
    clear_cap(); cap_on = 1;
    push(3'd0, 32'h0ABCDEF0);
    push(3'd1, 32'h01234560);
    en = 1;
    repeat (256) tick("d1");
    check_directed("d1", 24'hABCDEF, 24'h123456);
    cap_on = 0;
    go_idle("d1_stop");

    // D = 3, divider change while running is ignored
    div = 8'd3;
    repeat (2) tick("d3_idle");
    clear_cap(); cap_on = 1;
    push(3'd0, 32'h0ABCDEF0);
    push(3'd1, 32'h01234560);
    en = 1;
    tick("d3");
    div = 8'd5;
    repeat (256 * 3 - 1) tick("d3");
    check_directed("d3", 24'hABCDEF, 24'h123456);
    cap_on = 0;
    go_idle("d3_stop");

    // No stream data
    div = 8'd1;
    repeat (2) tick("nodata_idle");
    uf_cnt = 0; sd_ones = 0;
    en = 1;
    repeat (256) tick("nodata");
    check("nodata_uf_count", 32'(uf_cnt), 32'd4);
    check("nodata_sdata", 32'(sd_ones), 32'd0);
    go_idle("nodata_stop");

    // Out-of-order first beat
    a = $urandom; b = $urandom;
    clear_cap(); cap_on = 1; ce_cnt = 0;
    push(3'b001, $urandom);
    push(3'b000, a);
    push(3'b001, b);
    en = 1;
    repeat (256) tick("badtid");
    check("badtid_ce_count", 32'(ce_cnt), 32'd1);
    check("badtid_left", 32'(cap_word(65)), 32'(a[27:4]));
    check("badtid_right", 32'(cap_word(33)), 32'(b[27:4]));
    cap_on = 0;
    go_idle("badtid_stop");

    // Random traffic with divider 0 (acts as 1) and occasional wrong-channel beats
    div = 8'd0;
    repeat (2) tick("rand_idle");
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 7) == 0) push({2'($urandom), 1'b1}, $urandom);
      push_pair($urandom, $urandom);
    end
    en = 1;
    repeat (1024) tick("rand");

    // Disable at slot 10: frame completes, then restart from left
    run_to_slot("drop", 10, 1);
    en = 0;
    for (int i = 0; i < 200 && m_run; i++) tick("drop");
    check("drop_bound", 32'(m_run), 32'd0);
    check("drop_idle_outputs", 32'({sclk, lrclk, sdata, tready}), 32'd0);
    repeat (3) tick("drop_idle");
    push_pair($urandom, $urandom);
    push_pair($urandom, $urandom);
    en = 1;
    repeat (300) tick("reenable");

    // Reset mid-frame with buffers full
    for (int i = 0; i < 4; i++) push_pair($urandom, $urandom);
    run_to_slot("rst40", 40, 1);
    rst = 1;
    q.delete();
    tick("rst40");
    check("rst40_outputs", 32'({sclk, lrclk, sdata, uf, ce, tready}), 32'd0);
    rst = 0;
    uf_cnt = 0;
    repeat (130) tick("post_rst");
    check("post_rst_uf_count", 32'(uf_cnt), 32'd3);
    push_pair($urandom, $urandom);
    repeat (256) tick("post_rst_data");
    go_idle("final_stop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
